sp_instr_sequencer: RTL and testbench

// Upstream stage of the scratchpad. Pops one instrFIFO_t (matrix load, store, or GEMM) and expands it into per-row requests.

---
 rtl/sp_types_pkg.sv | 54 +++++
 rtl/sp_row_addr_gen.sv | 34 +++
 rtl/sp_instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_sp_instr_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_types_pkg.sv
// Shared types and constants for the scratchpad instruction sequencer.
package sp_types_pkg;

  localparam int WORD_W  = 32;
  localparam int MAT_S_W = 4;
  localparam int ROW_S_W = 2;
  localparam int MB_W    = 4;
  localparam int STRIDE  = 8;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_GEMM  = 2'b11;

  localparam logic [1:0] MAT_T_STORE  = 2'b00;
  localparam logic [1:0] MAT_T_WEIGHT = 2'b01;
  localparam logic [1:0] MAT_T_INPUT  = 2'b10;
  localparam logic [1:0] MAT_T_PSUM   = 2'b11;

  // Slot fields inside the GEMM select word; bits [15:12] are unused.
  localparam int GEMM_SEL_W_LSB = 0;
  localparam int GEMM_SEL_I_LSB = 4;
  localparam int GEMM_SEL_P_LSB = 8;
  localparam int NEW_WEIGHT_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_GEMM_W = 3'd3,
    ST_GEMM_I = 3'd4,
    ST_GEMM_P = 3'd5
  } sp_seq_state_t;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [MB_W-1:0]   ls_matrix_rd_gemm_new_weight;
    logic [WORD_W-1:0] ls_addr_gemm_gemm_sel;
  } instrFIFO_t;

  typedef struct packed {
    logic [WORD_W-1:0]  addr;
    logic [1:0]         mat_t;
    logic [MAT_S_W-1:0] mat_s;
    logic [ROW_S_W-1:0] row_s;
  } rFIFO_t;

  typedef struct packed {
    logic [WORD_W-1:0]  addr;
    logic [MAT_S_W-1:0] mat_s;
    logic [ROW_S_W-1:0] row_s;
  } ldreq_t;

endpackage

// File: rtl/sp_row_addr_gen.sv
// Row counter plus per-row byte address (base + rc*STRIDE, modulo 2**WORD_W).
module sp_row_addr_gen
  import sp_types_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_advance,
  input  logic [WORD_W-1:0]  i_base,
  output logic [ROW_S_W-1:0] o_rc,
  output logic [WORD_W-1:0]  o_addr
);

  logic [ROW_S_W-1:0] r_rc;
  logic [WORD_W-1:0]  w_offset;

  // Row counter: cleared on a new instruction, steps once per accepted row and wraps after the last row.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rc <= '0;
    end else if (i_advance) begin
      r_rc <= r_rc + 1'b1;
    end
  end

  // Row address; overflow past the top of the address space wraps silently.
  always_comb begin
    w_offset = WORD_W'(r_rc) * WORD_W'(STRIDE);
    o_addr   = i_base + w_offset;
  end

  assign o_rc = r_rc;

endmodule

// File: rtl/sp_instr_sequencer.sv
// Pops one instruction and expands it into per-row DRAM load requests or read-FIFO entries.
// Handshakes: a row is transferred in a cycle where its valid (ldreq_valid / rfifo_wen) and the
// sink's acceptance (ldreq_ready / !rfifo_full) are both high; an instruction is popped when
// instr_valid && instr_ready. Outputs are held unchanged while the sink stalls.
module sp_instr_sequencer
  import sp_types_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               instr_valid,
  input  instrFIFO_t         instr,
  output logic               instr_ready,
  output logic               rfifo_wen,
  input  logic               rfifo_full,
  output rFIFO_t             rfifo_wdata,
  output logic               ldreq_valid,
  input  logic               ldreq_ready,
  output logic [WORD_W-1:0]  ldreq_addr,
  output logic [MAT_S_W-1:0] ldreq_mat_s,
  output logic [ROW_S_W-1:0] ldreq_row_s,
  output logic               busy,
  output sp_seq_state_t      o_dbg_state
);

  sp_seq_state_t      r_state;
  sp_seq_state_t      w_next_state;
  logic [WORD_W-1:0]  r_base;
  logic [MAT_S_W-1:0] r_mat_s;
  logic [MAT_S_W-1:0] r_wsel;
  logic [MAT_S_W-1:0] r_isel;
  logic [MAT_S_W-1:0] r_psel;

  logic               w_pop;
  logic               w_row_accept;
  logic               w_last_row;
  logic               w_new_weight;
  logic [ROW_S_W-1:0] w_rc;
  logic [WORD_W-1:0]  w_row_addr;

  assign w_pop        = instr_valid && instr_ready;
  assign w_last_row   = (w_rc == '1);
  assign w_new_weight = instr.ls_matrix_rd_gemm_new_weight[NEW_WEIGHT_BIT];

  sp_row_addr_gen u_row_addr_gen (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clear   (w_pop),
    .i_advance (w_row_accept),
    .i_base    (r_base),
    .o_rc      (w_rc),
    .o_addr    (w_row_addr)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the instruction fields at pop time so the head of the instruction FIFO may change freely.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_base  <= '0;
      r_mat_s <= '0;
      r_wsel  <= '0;
      r_isel  <= '0;
      r_psel  <= '0;
    end else if (w_pop) begin
      r_base  <= instr.ls_addr_gemm_gemm_sel;
      r_mat_s <= instr.ls_matrix_rd_gemm_new_weight[MAT_S_W-1:0];
      r_wsel  <= instr.ls_addr_gemm_gemm_sel[GEMM_SEL_W_LSB +: MAT_S_W];
      r_isel  <= instr.ls_addr_gemm_gemm_sel[GEMM_SEL_I_LSB +: MAT_S_W];
      r_psel  <= instr.ls_addr_gemm_gemm_sel[GEMM_SEL_P_LSB +: MAT_S_W];
    end
  end

  // Next-state decode and per-state row outputs; everything is forced low during reset.
  always_comb begin
    w_next_state = r_state;
    w_row_accept = 1'b0;
    instr_ready  = 1'b0;
    rfifo_wen    = 1'b0;
    rfifo_wdata  = '0;
    ldreq_valid  = 1'b0;
    ldreq_addr   = '0;
    ldreq_mat_s  = '0;
    ldreq_row_s  = '0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (instr.opcode)
            OP_LOAD:  w_next_state = ST_LOAD;
            OP_STORE: w_next_state = ST_STORE;
            OP_GEMM:  w_next_state = w_new_weight ? ST_GEMM_W : ST_GEMM_I;
            default:  w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        ldreq_valid  = 1'b1;
        ldreq_addr   = w_row_addr;
        ldreq_mat_s  = r_mat_s;
        ldreq_row_s  = w_rc;
        w_row_accept = ldreq_ready;
        if (w_row_accept && w_last_row) w_next_state = ST_IDLE;
      end
      ST_STORE: begin
        rfifo_wen    = !rfifo_full;
        rfifo_wdata  = '{addr: w_row_addr, mat_t: MAT_T_STORE, mat_s: r_mat_s, row_s: w_rc};
        w_row_accept = !rfifo_full;
        if (w_row_accept && w_last_row) w_next_state = ST_IDLE;
      end
      ST_GEMM_W: begin
        rfifo_wen    = !rfifo_full;
        rfifo_wdata  = '{addr: '0, mat_t: MAT_T_WEIGHT, mat_s: r_wsel, row_s: w_rc};
        w_row_accept = !rfifo_full;
        if (w_row_accept && w_last_row) w_next_state = ST_GEMM_I;
      end
      ST_GEMM_I: begin
        rfifo_wen    = !rfifo_full;
        rfifo_wdata  = '{addr: '0, mat_t: MAT_T_INPUT, mat_s: r_isel, row_s: w_rc};
        w_row_accept = !rfifo_full;
        if (w_row_accept && w_last_row) w_next_state = ST_GEMM_P;
      end
      ST_GEMM_P: begin
        rfifo_wen    = !rfifo_full;
        rfifo_wdata  = '{addr: '0, mat_t: MAT_T_PSUM, mat_s: r_psel, row_s: w_rc};
        w_row_accept = !rfifo_full;
        if (w_row_accept && w_last_row) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (RST) begin
      w_row_accept = 1'b0;
      instr_ready  = 1'b0;
      rfifo_wen    = 1'b0;
      rfifo_wdata  = '0;
      ldreq_valid  = 1'b0;
      ldreq_addr   = '0;
      ldreq_mat_s  = '0;
      ldreq_row_s  = '0;
    end
  end

  assign busy        = (r_state != ST_IDLE) && !RST;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sp_instr_sequencer.sv
// Directed bench for sp_instr_sequencer: per-cycle vector table plus hand-written GEMM/reset sequences.
module tb_sp_instr_sequencer;
  import sp_types_pkg::*;

  logic          CLK;
  logic          RST;
  logic          instr_valid;
  instrFIFO_t    instr;
  logic          instr_ready;
  logic          rfifo_wen;
  logic          rfifo_full;
  rFIFO_t        rfifo_wdata;
  logic          ldreq_valid;
  logic          ldreq_ready;
  logic [31:0]   ldreq_addr;
  logic [3:0]    ldreq_mat_s;
  logic [1:0]    ldreq_row_s;
  logic          busy;
  sp_seq_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];

  localparam logic [1:0]  J_OP = 2'b11;
  localparam logic [3:0]  J_MB = 4'hF;
  localparam logic [31:0] J_LA = 32'hDEAD0000;

  sp_instr_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rfifo_wen   (rfifo_wen),
    .rfifo_full  (rfifo_full),
    .rfifo_wdata (rfifo_wdata),
    .ldreq_valid (ldreq_valid),
    .ldreq_ready (ldreq_ready),
    .ldreq_addr  (ldreq_addr),
    .ldreq_mat_s (ldreq_mat_s),
    .ldreq_row_s (ldreq_row_s),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // observed output bundle: {instr_ready, busy, wen, wdata[39:0], ldreq_valid, addr, mat_s, row_s}
  logic [81:0] obs;
  assign obs = {instr_ready, busy, rfifo_wen, rfifo_wdata, ldreq_valid, ldreq_addr, ldreq_mat_s, ldreq_row_s};

  function automatic logic [81:0] e_rst();
    return 82'd0;
  endfunction

  function automatic logic [81:0] e_idle();
    return {1'b1, 1'b0, 1'b0, 40'd0, 1'b0, 32'd0, 4'd0, 2'd0};
  endfunction

  function automatic logic [81:0] e_ld(input logic [31:0] a, input logic [3:0] ms, input logic [1:0] rs);
    return {1'b0, 1'b1, 1'b0, 40'd0, 1'b1, a, ms, rs};
  endfunction

  function automatic logic [81:0] e_rf(input logic wen, input logic [31:0] a, input logic [1:0] mt,
                                       input logic [3:0] ms, input logic [1:0] rs);
    return {1'b0, 1'b1, wen, a, mt, ms, rs, 1'b0, 32'd0, 4'd0, 2'd0};
  endfunction

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  op;
    logic [3:0]  mb;
    logic [31:0] la;
    logic        full;
    logic        lrdy;
    logic [81:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic iv, input logic [1:0] op, input logic [3:0] mb,
                              input logic [31:0] la, input logic full, input logic lrdy, input logic [81:0] e);
    vec_t v;
    v.rst = rst; v.iv = iv; v.op = op; v.mb = mb; v.la = la;
    v.full = full; v.lrdy = lrdy; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic iv, input logic [1:0] op, input logic [3:0] mb, input logic [31:0] la);
    instr_valid = iv;
    instr = '{opcode: op, ls_matrix_rd_gemm_new_weight: mb, ls_addr_gemm_gemm_sel: la};
  endtask

  // present one instruction for one cycle; returns at posedge+1 of the first row cycle
  task automatic issue(input logic [1:0] op, input logic [3:0] mb, input logic [31:0] la);
    @(posedge CLK); #1;
    set_instr(1'b1, op, mb, la);
    @(posedge CLK); #1;
    set_instr(1'b0, J_OP, J_MB, J_LA);
  endtask

  task automatic push_gemm(input logic nw, input logic [3:0] ws, input logic [3:0] is, input logic [3:0] ps);
    if (nw) for (int r = 0; r < 4; r++) exp_q.push_back({32'd0, 2'b01, ws, 2'(r)});
    for (int r = 0; r < 4; r++) exp_q.push_back({32'd0, 2'b10, is, 2'(r)});
    for (int r = 0; r < 4; r++) exp_q.push_back({32'd0, 2'b11, ps, 2'(r)});
  endtask

  // run until busy drops, checking each push against the scoreboard
  task automatic drain(input int stall_every, output int n_push, output int n_busy);
    logic done;
    logic [39:0] e;
    done = 1'b0;
    n_push = 0;
    n_busy = 0;
    for (int c = 0; c < 200; c++) begin
      rfifo_full = (stall_every != 0) && ((c % stall_every) == (stall_every - 1));
      @(negedge CLK);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n_busy++;
      if (rfifo_wen) begin
        n_push++;
        if (exp_q.size() == 0) begin
          check("extra push", 82'(rfifo_wdata), 82'(40'hFFFFFFFFFF));
        end else begin
          e = exp_q.pop_front();
          check("gemm row", 82'(rfifo_wdata), 82'(e));
        end
      end
      @(posedge CLK); #1;
    end
    rfifo_full = 1'b0;
    if (!done) check("drain timeout", 82'(0), 82'(1));
  endtask

  initial begin
    int n_push;
    int n_busy;
    int n;
    int after;
    RST = 1'b1;
    rfifo_full = 1'b0;
    ldreq_ready = 1'b0;
    set_instr(1'b0, J_OP, J_MB, J_LA);

    // ---- vector table ----
    tbl.push_back(mk(1, 0, J_OP, J_MB, J_LA, 0, 0, e_rst()));
    tbl.push_back(mk(1, 1, OP_LOAD, 4'd3, 32'h1000, 0, 1, e_rst()));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_idle()));
    // load mat 3 at 0x1000, sink always ready
    tbl.push_back(mk(0, 1, OP_LOAD, 4'd3, 32'h1000, 0, 1, e_idle()));
    for (int r = 0; r < 4; r++)
      tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'h1000 + 32'(8 * r), 4'd3, 2'(r))));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_idle()));
    // load mat 9 near top of address space, stalled two cycles on row 2
    tbl.push_back(mk(0, 1, OP_LOAD, 4'd9, 32'hFFFF_FFF8, 0, 1, e_idle()));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'hFFFF_FFF8, 4'd9, 2'd0)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'h0000_0000, 4'd9, 2'd1)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_ld(32'h0000_0008, 4'd9, 2'd2)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_ld(32'h0000_0008, 4'd9, 2'd2)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'h0000_0008, 4'd9, 2'd2)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'h0000_0010, 4'd9, 2'd3)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_idle()));
    // store mat 5 at 0x2000, FIFO full for 3 cycles on row 1
    tbl.push_back(mk(0, 1, OP_STORE, 4'd5, 32'h2000, 0, 0, e_idle()));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_rf(1, 32'h2000, 2'b00, 4'd5, 2'd0)));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 1, 0, e_rf(0, 32'h2008, 2'b00, 4'd5, 2'd1)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_rf(1, 32'h2008, 2'b00, 4'd5, 2'd1)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_rf(1, 32'h2010, 2'b00, 4'd5, 2'd2)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_rf(1, 32'h2018, 2'b00, 4'd5, 2'd3)));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 0, e_idle()));
    // NOP then load with instr_valid held
    tbl.push_back(mk(0, 1, OP_NOP, 4'hF, 32'h1234, 0, 1, e_idle()));
    tbl.push_back(mk(0, 1, OP_LOAD, 4'd2, 32'h40, 0, 1, e_idle()));
    for (int r = 0; r < 4; r++)
      tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_ld(32'h40 + 32'(8 * r), 4'd2, 2'(r))));
    tbl.push_back(mk(0, 0, J_OP, J_MB, J_LA, 0, 1, e_idle()));

    foreach (tbl[i]) begin
      @(posedge CLK); #1;
      RST = tbl[i].rst;
      set_instr(tbl[i].iv, tbl[i].op, tbl[i].mb, tbl[i].la);
      rfifo_full = tbl[i].full;
      ldreq_ready = tbl[i].lrdy;
      @(negedge CLK);
      check($sformatf("vec[%0d]", i), obs, tbl[i].exp);
    end
    set_instr(1'b0, J_OP, J_MB, J_LA);
    rfifo_full = 1'b0;
    ldreq_ready = 1'b1;

    // ---- GEMM with new weight, unstalled; bits [15:12] of select must be ignored ----
    push_gemm(1'b1, 4'd1, 4'd2, 4'd3);
    issue(OP_GEMM, 4'h8, 32'hABCD_F321);
    drain(0, n_push, n_busy);
    check("gemm_nw1 pushes", 82'(n_push), 82'(12));
    check("gemm_nw1 busy cycles", 82'(n_busy), 82'(12));
    check("gemm_nw1 leftover", 82'(exp_q.size()), 82'(0));

    // ---- same GEMM with periodic FIFO-full stalls ----
    exp_q.delete();
    push_gemm(1'b1, 4'd1, 4'd2, 4'd3);
    issue(OP_GEMM, 4'h8, 32'h0000_0321);
    drain(3, n_push, n_busy);
    check("gemm_stall pushes", 82'(n_push), 82'(12));
    check("gemm_stall leftover", 82'(exp_q.size()), 82'(0));

    // ---- GEMM without new weight: input then psum only ----
    exp_q.delete();
    push_gemm(1'b0, 4'd1, 4'd2, 4'd3);
    issue(OP_GEMM, 4'h7, 32'h0000_0321);
    drain(0, n_push, n_busy);
    check("gemm_nw0 pushes", 82'(n_push), 82'(8));
    check("gemm_nw0 busy cycles", 82'(n_busy), 82'(8));
    check("gemm_nw0 leftover", 82'(exp_q.size()), 82'(0));

    // ---- reset after the 5th GEMM row ----
    exp_q.delete();
    push_gemm(1'b1, 4'd1, 4'd2, 4'd3);
    issue(OP_GEMM, 4'h8, 32'h0000_0321);
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      @(negedge CLK);
      if (rfifo_wen) begin
        n++;
        check("rst_gemm row", 82'(rfifo_wdata), 82'(exp_q.pop_front()));
      end
      @(posedge CLK); #1;
    end
    check("rst_gemm rows before reset", 82'(n), 82'(5));
    RST = 1'b1;
    after = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("outputs during reset", obs, e_rst());
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(negedge CLK);
    check("idle after reset", obs, e_idle());
    check("state after reset", 82'(dbg_state), 82'(ST_IDLE));
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (rfifo_wen) after++;
    end
    check("pushes after reset", 82'(after), 82'(0));
    exp_q.delete();

    // ---- load executes normally after the aborted GEMM ----
    issue(OP_LOAD, 4'd1, 32'h3000);
    for (int r = 0; r < 4; r++) begin
      @(negedge CLK);
      check($sformatf("post_rst load row %0d", r), obs, e_ld(32'h3000 + 32'(8 * r), 4'd1, 2'(r)));
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("post_rst load idle", obs, e_idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
